multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and raises sticky illegal/fault flags that park the machine in HALT until reset.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t         state_q, state_next;
    logic [CW-1:0]  waitcnt, waitcnt_next;
    logic           set_illegal, set_fault;
    logic [6:0]     opcode;
    logic           is_store, legal, timeout, decode_en;

    assign opcode    = instr[6:0];
    assign is_store  = (opcode == OPC_STORE);
    assign timeout   = (waitcnt == CW'(MEM_TIMEOUT)) && !mem_ready;
    assign decode_en = (state_q == DECODE) || (state_q == EXEC) ||
                       (state_q == MEM)    || (state_q == WB);
    assign state     = state_q;

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_type  = 3'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        if (decode_en) begin
            case (opcode)
                OPC_OP:     alu_op = 2'd2;
                OPC_OPIMM:  begin alu_src_b = 1'b1; alu_op = 2'd2; end
                OPC_LOAD:   alu_src_b = 1'b1;
                OPC_STORE:  begin imm_type = 3'd1; alu_src_b = 1'b1; end
                OPC_BRANCH: begin imm_type = 3'd2; alu_op = 2'd1; end
                OPC_JAL:    begin imm_type = 3'd4; alu_src_a = 2'd1; alu_src_b = 1'b1; end
                OPC_JALR:   alu_src_b = 1'b1;
                OPC_LUI:    begin imm_type = 3'd3; alu_src_a = 2'd2; alu_src_b = 1'b1; end
                OPC_AUIPC:  begin imm_type = 3'd3; alu_src_a = 2'd1; alu_src_b = 1'b1; end
                default:    ;
            endcase
        end
    end

    // Strobes are combinational so a completing mem_ready is acted on in its own cycle.
    always_comb begin
        state_next  = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        pc_src      = 2'd0;
        wb_sel      = 2'd0;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    set_fault  = 1'b1;
                    state_next = HALT;
                end
            end
            DECODE: begin
                if (!legal) begin
                    set_illegal = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (opcode)
                    OPC_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_src     = branch_cond ? 2'd1 : 2'd0;
                        state_next = FETCH;
                    end
                    OPC_LOAD, OPC_STORE: state_next = MEM;
                    default:             state_next = WB;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (timeout) begin
                    set_fault  = 1'b1;
                    state_next = HALT;
                end
            end
            WB: begin
                reg_write = (instr[11:7] != 5'd0);
                pc_write  = 1'b1;
                case (opcode)
                    OPC_LOAD: wb_sel = 2'd1;
                    OPC_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
                    OPC_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
                    default:  ;
                endcase
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // The counter restarts on every state change, so it is fresh on entry to FETCH or MEM.
    always_comb begin
        waitcnt_next = waitcnt;
        if (state_next != state_q)
            waitcnt_next = '0;
        else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ready && !timeout)
            waitcnt_next = waitcnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            waitcnt <= '0;
            illegal <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_next;
            waitcnt <= waitcnt_next;
            if (set_illegal)
                illegal <= 1'b1;
            if (set_fault)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and checks state, strobes and select outputs against hand-derived values.
module tb_multicycle_ctrl;

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] BEQ   = 32'h00000463;
    localparam logic [31:0] JAL0  = 32'h0080006F;
    localparam logic [31:0] JALR1 = 32'h000100E7;
    localparam logic [31:0] LUI   = 32'h123451B7;
    localparam logic [31:0] AUIPC = 32'h00000297;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] ILL   = 32'h0000007F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_cond;
    logic        mem_req, mem_we, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src, wb_sel, alu_src_a, alu_op;
    logic        alu_src_b;
    logic [2:0]  imm_type;
    logic        illegal, fault;
    logic [2:0]  state;
    logic [4:0]  strobes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign strobes = {mem_req, mem_we, ir_write, pc_write, reg_write};

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .branch_cond (branch_cond),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .wb_sel      (wb_sel),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .imm_type    (imm_type),
        .illegal     (illegal),
        .fault       (fault),
        .state       (state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 2 time units later.
    task automatic applyStimulus(input logic [31:0] i, input logic mr, input logic bc, input logic rst);
        @(negedge clk);
        instr       = i;
        mem_ready   = mr;
        branch_cond = bc;
        reset       = rst;
        #2;
    endtask

    // Strobe vector order: {mem_req, mem_we, ir_write, pc_write, reg_write}.
    task automatic runCycle(input string tag, input logic [31:0] i, input logic mr, input logic bc,
                            input logic [2:0] expState, input logic [4:0] expStrb,
                            input logic [1:0] expPcSrc, input logic [1:0] expWbSel);
        applyStimulus(i, mr, bc, 1'b0);
        checkOutput({tag, ".state"}, 32'(state), 32'(expState));
        checkOutput({tag, ".strb"}, 32'(strobes), 32'(expStrb));
        if (expStrb[1])
            checkOutput({tag, ".pc_src"}, 32'(pc_src), 32'(expPcSrc));
        if (expStrb[0])
            checkOutput({tag, ".wb_sel"}, 32'(wb_sel), 32'(expWbSel));
    endtask

    initial begin
        reset = 1'b1; instr = '0; mem_ready = 1'b0; branch_cond = 1'b0;

        applyStimulus(ADDI, 1'b1, 1'b0, 1'b1);
        checkOutput("rst0.strb", 32'(strobes), 32'd0);
        applyStimulus(ADDI, 1'b1, 1'b0, 1'b1);
        checkOutput("rst1.strb", 32'(strobes), 32'd0);

        runCycle("addi.f", ADDI, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        checkOutput("addi.illegal", 32'(illegal), 32'd0);
        runCycle("addi.d", ADDI, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("addi.imm", 32'(imm_type), 32'd0);
        checkOutput("addi.b", 32'(alu_src_b), 32'd1);
        checkOutput("addi.op", 32'(alu_op), 32'd2);
        runCycle("addi.e", ADDI, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("addi.w", ADDI, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd0);

        runCycle("lw.f", LW, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("lw.d", LW, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("lw.op", 32'(alu_op), 32'd0);
        runCycle("lw.e", LW, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        for (int k = 0; k < 3; k++)
            runCycle("lw.mwait", LW, 0, 0, 3'd3, 5'b10000, 2'd0, 2'd0);
        runCycle("lw.mdone", LW, 1, 0, 3'd3, 5'b10000, 2'd0, 2'd0);
        runCycle("lw.w", LW, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd1);

        runCycle("sw.f", SW, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("sw.d", SW, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("sw.imm", 32'(imm_type), 32'd1);
        runCycle("sw.e", SW, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("sw.m", SW, 1, 0, 3'd3, 5'b11010, 2'd0, 2'd0);

        runCycle("beq1.f", BEQ, 1, 1, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("beq1.d", BEQ, 1, 1, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("beq.imm", 32'(imm_type), 32'd2);
        checkOutput("beq.op", 32'(alu_op), 32'd1);
        checkOutput("beq.b", 32'(alu_src_b), 32'd0);
        runCycle("beq1.e", BEQ, 1, 1, 3'd2, 5'b00010, 2'd1, 2'd0);
        runCycle("beq0.f", BEQ, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("beq0.d", BEQ, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        runCycle("beq0.e", BEQ, 1, 0, 3'd2, 5'b00010, 2'd0, 2'd0);

        runCycle("jal.f", JAL0, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("jal.d", JAL0, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("jal.imm", 32'(imm_type), 32'd4);
        runCycle("jal.e", JAL0, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("jal.w", JAL0, 1, 0, 3'd4, 5'b00010, 2'd1, 2'd0);

        runCycle("jalr.f", JALR1, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("jalr.d", JALR1, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("jalr.imm", 32'(imm_type), 32'd0);
        runCycle("jalr.e", JALR1, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("jalr.w", JALR1, 1, 0, 3'd4, 5'b00011, 2'd2, 2'd2);

        runCycle("lui.f", LUI, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("lui.d", LUI, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("lui.imm", 32'(imm_type), 32'd3);
        checkOutput("lui.a", 32'(alu_src_a), 32'd2);
        runCycle("lui.e", LUI, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("lui.w", LUI, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd0);

        runCycle("auipc.f", AUIPC, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("auipc.d", AUIPC, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("auipc.a", 32'(alu_src_a), 32'd1);
        runCycle("auipc.e", AUIPC, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("auipc.w", AUIPC, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd0);

        runCycle("add.f", ADD, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("add.d", ADD, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("add.b", 32'(alu_src_b), 32'd0);
        checkOutput("add.op", 32'(alu_op), 32'd2);
        runCycle("add.e", ADD, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("add.w", ADD, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd0);

        runCycle("ill.f", ILL, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("ill.d", ILL, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            runCycle("ill.halt", ILL, 1'(k), 0, 3'd5, 5'b00000, 2'd0, 2'd0);
            checkOutput("ill.flag", 32'(illegal), 32'd1);
        end
        applyStimulus(ILL, 1'b1, 1'b0, 1'b1);
        checkOutput("ill.rst.strb", 32'(strobes), 32'd0);

        // Timeout with MEM_TIMEOUT=15: 15 waiting cycles, fault taken in the 16th.
        for (int k = 0; k < 16; k++) begin
            runCycle("to.fetch", ADDI, 0, 0, 3'd0, 5'b10000, 2'd0, 2'd0);
            if (k == 0)
                checkOutput("to.illclr", 32'(illegal), 32'd0);
        end
        runCycle("to.halt", ADDI, 0, 0, 3'd5, 5'b00000, 2'd0, 2'd0);
        checkOutput("to.fault", 32'(fault), 32'd1);
        applyStimulus(ADDI, 1'b0, 1'b0, 1'b1);
        checkOutput("to.rst.strb", 32'(strobes), 32'd0);

        for (int k = 0; k < 15; k++)
            runCycle("win.fetch", ADDI, 0, 0, 3'd0, 5'b10000, 2'd0, 2'd0);
        runCycle("win.ready", ADDI, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("win.d", ADDI, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        checkOutput("win.fault", 32'(fault), 32'd0);
        runCycle("win.e", ADDI, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("win.w", ADDI, 1, 0, 3'd4, 5'b00011, 2'd0, 2'd0);

        runCycle("mrst.f", SW, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        runCycle("mrst.d", SW, 1, 0, 3'd1, 5'b00000, 2'd0, 2'd0);
        runCycle("mrst.e", SW, 1, 0, 3'd2, 5'b00000, 2'd0, 2'd0);
        runCycle("mrst.m0", SW, 0, 0, 3'd3, 5'b11000, 2'd0, 2'd0);
        runCycle("mrst.m1", SW, 0, 0, 3'd3, 5'b11000, 2'd0, 2'd0);
        applyStimulus(SW, 1'b1, 1'b0, 1'b1);
        checkOutput("mrst.rst.strb", 32'(strobes), 32'd0);
        runCycle("mrst.after", SW, 1, 0, 3'd0, 5'b10100, 2'd0, 2'd0);
        checkOutput("mrst.fault", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
